// File: rtl/attack_phase_ctrl_pkg.sv
// rtl/attack_phase_ctrl_pkg.sv - shared phase encodings, attack types and default phase lengths
package attack_phase_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STARTUP  = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_RECOVERY = 3'd3,
        ST_HITSTUN  = 3'd4
    } phase_e;

    localparam logic ATK_BASIC = 1'b0;
    localparam logic ATK_DIR   = 1'b1;

    localparam int DEF_WIDTH          = 5;
    localparam int DEF_BASIC_STARTUP  = 3;
    localparam int DEF_BASIC_ACTIVE   = 2;
    localparam int DEF_BASIC_RECOVERY = 4;
    localparam int DEF_DIR_STARTUP    = 4;
    localparam int DEF_DIR_ACTIVE     = 3;
    localparam int DEF_DIR_RECOVERY   = 6;
    localparam int DEF_HITSTUN        = 8;

    // A length must be representable on the counter limit bus.
    function automatic bit len_fits(input int len, input int width);
        return (len >= 0) && (len < (1 << width));
    endfunction

endpackage

// File: rtl/attack_phase_ctrl_len_sel.sv
// rtl/attack_phase_ctrl_len_sel.sv - (type, phase) length lookup and next-nonzero-phase selection
module attack_len_sel
    import attack_phase_ctrl_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BASIC_STARTUP  = DEF_BASIC_STARTUP,
    parameter int BASIC_ACTIVE   = DEF_BASIC_ACTIVE,
    parameter int BASIC_RECOVERY = DEF_BASIC_RECOVERY,
    parameter int DIR_STARTUP    = DEF_DIR_STARTUP,
    parameter int DIR_ACTIVE     = DEF_DIR_ACTIVE,
    parameter int DIR_RECOVERY   = DEF_DIR_RECOVERY
) (
    input  logic             atk_type,
    input  phase_e           from_phase,
    output phase_e           next_phase,
    output logic [WIDTH-1:0] next_len
);

    localparam logic [WIDTH-1:0] B_S = BASIC_STARTUP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] B_A = BASIC_ACTIVE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] B_R = BASIC_RECOVERY[WIDTH-1:0];
    localparam logic [WIDTH-1:0] D_S = DIR_STARTUP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] D_A = DIR_ACTIVE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] D_R = DIR_RECOVERY[WIDTH-1:0];

    logic [WIDTH-1:0] len_s;
    logic [WIDTH-1:0] len_a;
    logic [WIDTH-1:0] len_r;

    // Walk forward from from_phase to the first phase with a nonzero length; IDLE when none is left.
    always_comb begin
        len_s      = (atk_type == ATK_DIR) ? D_S : B_S;
        len_a      = (atk_type == ATK_DIR) ? D_A : B_A;
        len_r      = (atk_type == ATK_DIR) ? D_R : B_R;
        next_phase = ST_IDLE;
        case (from_phase)
            ST_IDLE: begin
                if (len_s != '0)      next_phase = ST_STARTUP;
                else if (len_a != '0) next_phase = ST_ACTIVE;
                else if (len_r != '0) next_phase = ST_RECOVERY;
            end
            ST_STARTUP: begin
                if (len_a != '0)      next_phase = ST_ACTIVE;
                else if (len_r != '0) next_phase = ST_RECOVERY;
            end
            ST_ACTIVE: begin
                if (len_r != '0)      next_phase = ST_RECOVERY;
            end
            default: next_phase = ST_IDLE;
        endcase
        case (next_phase)
            ST_STARTUP:  next_len = len_s;
            ST_ACTIVE:   next_len = len_a;
            ST_RECOVERY: next_len = len_r;
            default:     next_len = '0;
        endcase
    end

endmodule

// File: rtl/attack_phase_ctrl.sv
// rtl/attack_phase_ctrl.sv - attack phase sequencer driving the duration counter; ATK_INPUT_BUFFER_EN adds a recovery request buffer
module attack_phase_ctrl
    import attack_phase_ctrl_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BASIC_STARTUP  = DEF_BASIC_STARTUP,
    parameter int BASIC_ACTIVE   = DEF_BASIC_ACTIVE,
    parameter int BASIC_RECOVERY = DEF_BASIC_RECOVERY,
    parameter int DIR_STARTUP    = DEF_DIR_STARTUP,
    parameter int DIR_ACTIVE     = DEF_DIR_ACTIVE,
    parameter int DIR_RECOVERY   = DEF_DIR_RECOVERY,
    parameter int HITSTUN        = DEF_HITSTUN
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             i_atk_basic,
    input  logic             i_atk_dir,
    input  logic             i_hit,
    input  logic             i_cnt_done,
    output logic             o_cnt_enable,
    output logic             o_cnt_stop,
    output logic [WIDTH-1:0] o_cnt_limit,
    output logic [2:0]       o_phase,
    output logic             o_atk_type,
    output logic             o_hitbox,
    output logic             o_busy
);

    localparam logic [WIDTH-1:0] HIT_LEN = HITSTUN[WIDTH-1:0];
    localparam bit LEN_OK = len_fits(BASIC_STARTUP, WIDTH) && len_fits(BASIC_ACTIVE, WIDTH) &&
                            len_fits(BASIC_RECOVERY, WIDTH) && len_fits(DIR_STARTUP, WIDTH) &&
                            len_fits(DIR_ACTIVE, WIDTH) && len_fits(DIR_RECOVERY, WIDTH) &&
                            len_fits(HITSTUN, WIDTH);

    phase_e           state;
    phase_e           nxt_state;
    phase_e           q_from;
    phase_e           sel_phase;
    logic             req;
    logic             req_type;
    logic             q_type;
    logic             nxt_type;
    logic             nxt_stop;
    logic [WIDTH-1:0] sel_len;
    logic [WIDTH-1:0] nxt_limit;

    assign req      = i_atk_basic | i_atk_dir;
    assign req_type = i_atk_dir ? ATK_DIR : ATK_BASIC;

`ifdef ATK_INPUT_BUFFER_EN
    logic buf_valid;
    logic buf_type;
    logic nxt_buf_valid;
    logic nxt_buf_type;
    logic eff_valid;
    logic eff_type;

    // A request on the final recovery cycle is honoured like a buffered one.
    assign eff_valid = buf_valid | req;
    assign eff_type  = buf_valid ? buf_type : req_type;
`endif

    attack_len_sel #(
        .WIDTH          (WIDTH),
        .BASIC_STARTUP  (BASIC_STARTUP),
        .BASIC_ACTIVE   (BASIC_ACTIVE),
        .BASIC_RECOVERY (BASIC_RECOVERY),
        .DIR_STARTUP    (DIR_STARTUP),
        .DIR_ACTIVE     (DIR_ACTIVE),
        .DIR_RECOVERY   (DIR_RECOVERY)
    ) u_len_sel (
        .atk_type   (q_type),
        .from_phase (q_from),
        .next_phase (sel_phase),
        .next_len   (sel_len)
    );

    // Choose which attack the lookup walks: a new request from IDLE, a queued one at end of recovery, else the current one.
    always_comb begin
        q_type = o_atk_type;
        q_from = state;
        if (state == ST_IDLE) q_type = req_type;
`ifdef ATK_INPUT_BUFFER_EN
        if ((state == ST_RECOVERY) && eff_valid) begin
            q_type = eff_type;
            q_from = ST_IDLE;
        end
`endif
    end

    // Next-state logic with hit taking precedence over counter done, and done over requests.
    always_comb begin
        nxt_state = state;
        nxt_limit = o_cnt_limit;
        nxt_stop  = 1'b0;
        nxt_type  = o_atk_type;
`ifdef ATK_INPUT_BUFFER_EN
        nxt_buf_valid = buf_valid;
        nxt_buf_type  = buf_type;
`endif
        if (i_hit) begin
            nxt_stop  = 1'b1;
            nxt_limit = HIT_LEN;
            nxt_state = (HITSTUN != 0) ? ST_HITSTUN : ST_IDLE;
`ifdef ATK_INPUT_BUFFER_EN
            nxt_buf_valid = 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && (sel_phase != ST_IDLE)) begin
                        nxt_state = sel_phase;
                        nxt_limit = sel_len;
                        nxt_type  = req_type;
                    end
                end
                ST_STARTUP, ST_ACTIVE: begin
                    if (i_cnt_done) begin
                        nxt_state = sel_phase;
                        nxt_limit = sel_len;
                    end
                end
                ST_RECOVERY: begin
                    if (i_cnt_done) begin
                        nxt_state = sel_phase;
                        nxt_limit = sel_len;
`ifdef ATK_INPUT_BUFFER_EN
                        if (eff_valid) nxt_type = eff_type;
                        nxt_buf_valid = 1'b0;
                    end else if (req && !buf_valid) begin
                        nxt_buf_valid = 1'b1;
                        nxt_buf_type  = req_type;
`endif
                    end
                end
                ST_HITSTUN: begin
                    if (i_cnt_done) begin
                        nxt_state = ST_IDLE;
                        nxt_limit = '0;
                    end
                end
                default: begin
                    nxt_state = ST_IDLE;
                    nxt_limit = '0;
                end
            endcase
        end
    end

    // State and registered outputs, all derived from the next state so they change on the same edge.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= ST_IDLE;
            o_phase      <= 3'd0;
            o_cnt_enable <= 1'b0;
            o_cnt_stop   <= 1'b0;
            o_cnt_limit  <= '0;
            o_atk_type   <= 1'b0;
            o_hitbox     <= 1'b0;
            o_busy       <= 1'b0;
`ifdef ATK_INPUT_BUFFER_EN
            buf_valid    <= 1'b0;
            buf_type     <= 1'b0;
`endif
        end else begin
            state        <= nxt_state;
            o_phase      <= nxt_state;
            o_cnt_enable <= (nxt_state != ST_IDLE);
            o_cnt_stop   <= nxt_stop;
            o_cnt_limit  <= nxt_limit;
            o_atk_type   <= nxt_type;
            o_hitbox     <= (nxt_state == ST_ACTIVE);
            o_busy       <= (nxt_state != ST_IDLE);
`ifdef ATK_INPUT_BUFFER_EN
            buf_valid    <= nxt_buf_valid;
            buf_type     <= nxt_buf_type;
`endif
        end
    end

    // Flag phase lengths that do not fit the counter limit bus.
    always_ff @(posedge clk) begin
        assert (LEN_OK) else $error("attack_phase_ctrl: a phase length does not fit in WIDTH bits");
    end

endmodule

// File: doc/attack_phase_ctrl.md
Name: attack_phase_ctrl

Overview:
Per-player attack sequencer that drives the shared dynamic duration counter. Starts on an attack request and steps through STARTUP -> ACTIVE -> RECOVERY, with HITSTUN on interrupt. For each phase it loads the counter's enable, stop and limit inputs, and advances when the counter reports done. Its phase and hitbox outputs feed the collision and sprite logic.

Parameters:
WIDTH, 5, width of the counter limit bus; must match the counter instance.
BASIC_STARTUP, 3, basic-attack startup length L.
BASIC_ACTIVE, 2, basic-attack active length L.
BASIC_RECOVERY, 4, basic-attack recovery length L.
DIR_STARTUP, 4, directional-attack startup length L.
DIR_ACTIVE, 3, directional-attack active length L.
DIR_RECOVERY, 6, directional-attack recovery length L.
HITSTUN, 8, hitstun length L.

Ports:
clk  in  1  system clock; the only clock.
nRst  in  1  reset; asynchronous, active-low.
i_atk_basic  in  1  basic attack request, level-sampled.
i_atk_dir  in  1  directional attack request, level-sampled.
i_hit  in  1  player was hit this cycle.
i_cnt_done  in  1  done pulse from the duration counter.
o_cnt_enable  out  1  counter run enable.
o_cnt_stop  out  1  counter synchronous clear.
o_cnt_limit  out  WIDTH  counter limit for the current phase.
o_phase  out  3  current state encoding.
o_atk_type  out  1  0 = basic, 1 = directional; valid while an attack is in progress.
o_hitbox  out  1  high only in ACTIVE.
o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset: state IDLE; all outputs 0; o_cnt_limit 0. A reset mid-attack returns to IDLE immediately.
- States and encodings: IDLE=0, STARTUP=1, ACTIVE=2, RECOVERY=3, HITSTUN=4.
- IDLE: o_cnt_enable=0.
  - A request moves to the first attack phase with nonzero length.
  - If both requests are high, directional wins; o_atk_type is latched on acceptance.
  - If all three lengths for the selected attack are 0, the request is ignored.
- Attack phases:
  - o_cnt_enable=1 and o_cnt_limit=L of the current phase.
  - On a cycle with i_cnt_done=1, advance to the next nonzero phase; after RECOVERY, go to IDLE.
  - Phases with L=0 are skipped, never loaded; loading 0 would wrap the counter to 2^WIDTH.
  - With the counter attached, each phase lasts exactly L+1 cycles.
- Requests arriving while the state is not IDLE are dropped.
- i_cnt_done in IDLE is ignored.
- i_hit in any state goes to HITSTUN, or to IDLE if HITSTUN=0.
  - On that transition o_cnt_stop=1 for exactly one cycle and o_cnt_limit=HITSTUN.
  - o_cnt_enable=1 during HITSTUN, so HITSTUN lasts HITSTUN+2 cycles.
  - i_hit during HITSTUN restarts it, with a new stop pulse.
- Priority within a cycle: i_hit > i_cnt_done > requests.
- o_hitbox falls on the same edge that leaves ACTIVE.
- Lengths wider than WIDTH bits are a configuration error, flagged by a simulation-only check.

Optional Feature:
Macro: ATK_INPUT_BUFFER_EN.
- Defined: a one-deep request buffer, with type, captures the first request arriving during RECOVERY. Directional overwrites basic in the same cycle.
- On the RECOVERY-done transition with a buffered request, go directly to that attack's first nonzero phase, skipping IDLE, and clear the buffer.
- The buffer is cleared by i_hit and by reset.
- Undefined: no buffer; requests outside IDLE are dropped.

Decomposition:
- Shared package: state encoding constants, attack type constants, default phase lengths.
- Natural sub-module: attack_len_sel. Combinational lookup of (type, phase) -> L plus a next-nonzero-phase function. Reused by the planned combo controller.

Test Plan:
- Basic request 1 cycle, defaults -> STARTUP 4 cycles, ACTIVE 3 (o_hitbox high 3 cycles), RECOVERY 5; o_busy high 12 cycles; limits 3/2/4.
- i_atk_basic and i_atk_dir high together -> o_atk_type=1; phases 5/4/7 cycles, o_busy high 16 cycles.
- i_hit in 2nd ACTIVE cycle -> next edge phase=4, o_hitbox=0, o_cnt_stop high 1 cycle, limit 8; back to IDLE after 10 cycles. Second i_hit mid-HITSTUN -> restarts the 10-cycle count.
- BASIC_ACTIVE=0 -> STARTUP goes straight to RECOVERY, o_hitbox never high. HITSTUN=0 plus i_hit -> IDLE with a stop pulse.
- nRst low mid-RECOVERY -> all outputs 0 asynchronously; a request 2 cycles after release is accepted normally.
- With ATK_INPUT_BUFFER_EN: basic request during RECOVERY -> STARTUP on the cycle after RECOVERY ends, no IDLE cycle. Without the macro -> the same request is dropped and the state stays IDLE.
